// File: rtl/data_serializer.sv
// data_serializer: buffers wide words in a small FIFO and emits each as 1..RATIO narrow beats.
// Ports:
//   clk, reset_n      rising-edge clock, asynchronous active-low reset
//   clear_i           synchronous flush of FIFO and output stage (wins over push/pop)
//   valid_i/ready_o   wide-side handshake; ready_o = ~full, derived from registered state
//   data_i, len_i     wide word and its beat count (0 or >RATIO means RATIO)
//   data_o/valid_o    current narrow beat; ready_i accepts it
//   last_o, idx_o     final-beat flag and beat index within the word
//   level_o           words waiting in the FIFO, output stage excluded
// Build option: define SERIALIZER_MSB_FIRST_EN to emit beats from the MSB end.
module data_serializer #(
    parameter int DATA_INPUT_WIDTH  = 256,
    parameter int DATA_OUTPUT_WIDTH = 32,
    parameter int DEPTH             = 2,
    localparam int RATIO = DATA_INPUT_WIDTH / DATA_OUTPUT_WIDTH,
    localparam int LW    = $clog2(RATIO) + 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [DATA_INPUT_WIDTH-1:0]  data_i,
    input  logic [LW-1:0]                len_i,
    output logic [DATA_OUTPUT_WIDTH-1:0] data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         last_o,
    output logic [LW-2:0]                idx_o,
    output logic [CW-1:0]                level_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_INPUT_WIDTH-1:0] mem_data [DEPTH];
    logic [LW-1:0]               mem_len  [DEPTH];
    logic [PW-1:0]               wr_ptr, rd_ptr;
    logic [CW-1:0]               count;
    logic [DATA_INPUT_WIDTH-1:0] shift_reg, shifted;
    logic [LW-1:0]               beat_len, len_norm;
    logic [LW-2:0]               beat_idx;
    logic                        stage_valid, push, pop, xfer, last;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o  = (count != CW'(DEPTH));
    assign push     = valid_i & ready_o;
    assign xfer     = stage_valid & ready_i;
    assign last     = stage_valid & ({1'b0, beat_idx} == beat_len - 1'b1);
    // The stage refills either when idle or in the same cycle its last beat leaves,
    // which is what gives back-to-back words without a bubble.
    assign pop      = (count != '0) & (~stage_valid | (xfer & last));
    assign len_norm = (len_i == '0 || len_i > LW'(RATIO)) ? LW'(RATIO) : len_i;

    assign valid_o  = stage_valid;
    assign last_o   = last;
    assign idx_o    = beat_idx;
    assign level_o  = count;

`ifdef SERIALIZER_MSB_FIRST_EN
    assign data_o  = shift_reg[DATA_INPUT_WIDTH-1 -: DATA_OUTPUT_WIDTH];
    assign shifted = shift_reg << DATA_OUTPUT_WIDTH;
`else
    assign data_o  = shift_reg[DATA_OUTPUT_WIDTH-1:0];
    assign shifted = shift_reg >> DATA_OUTPUT_WIDTH;
`endif

    always_ff @(posedge clk) begin
        if (push && !clear_i) begin
            mem_data[wr_ptr] <= data_i;
            mem_len[wr_ptr]  <= len_norm;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || clear_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            shift_reg   <= '0;
            beat_len    <= '0;
            beat_idx    <= '0;
            stage_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wrap_inc(wr_ptr);
            if (pop) rd_ptr <= wrap_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
            if (pop) begin
                shift_reg   <= mem_data[rd_ptr];
                beat_len    <= mem_len[rd_ptr];
                beat_idx    <= '0;
                stage_valid <= 1'b1;
            end else if (xfer) begin
                // Draining the final beat zeroes the stage so no stale data lingers on data_o.
                shift_reg   <= last ? '0 : shifted;
                beat_idx    <= last ? '0 : beat_idx + 1'b1;
                stage_valid <= ~last;
            end
        end
    end
endmodule
